// File: rtl/inv_cipher.sv
// Iterative AES inverse cipher: one inverse round per clock from a
// forward-ordered expanded key schedule, start/busy/done handshake.
module inv_cipher #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic                   clks,
  input  logic                   reset,
  input  logic                   start,
  input  logic [0:127]           cipherText,
  input  logic [0:128*(Nr+1)-1]  keys,
  output logic [0:127]           plainText,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE,
    ROUNDS,
    FINAL
  } state_t;

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [0:127] r_state;
  logic [4:0]   r_rnd;

  logic [4:0]   w_kidx;
  logic [0:127] w_rk;
  logic [0:127] w_isr;
  logic [0:127] w_isb;
  logic [0:127] w_ark;
  logic [0:127] w_imc;

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse affine, then x^254 (= x^-1, and 0 -> 0) by repeated squaring.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    logic [7:0] t;
    logic [7:0] r;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    t = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r;
  endfunction

  function automatic logic [31:0] imc_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    imc_col[31:24] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                   ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    imc_col[23:16] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                   ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    imc_col[15:8]  = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                   ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    imc_col[7:0]   = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                   ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
  endfunction

  // IDLE whitens with key[Nr]; FINAL reaches key[0] since rnd has hit 0.
  always_comb begin
    w_kidx = (r_fsm == IDLE) ? 5'(Nr) : r_rnd;
    w_rk   = keys[128*w_kidx +: 128];
  end

  always_comb begin
    w_isr = '0;
    w_isb = '0;
    w_imc = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_isr[8*(r+4*c) +: 8] = r_state[8*(r+4*((c-r)&3)) +: 8];
      end
    end
    for (int i = 0; i < 16; i++) begin
      w_isb[8*i +: 8] = inv_sbox(w_isr[8*i +: 8]);
    end
    w_ark = w_isb ^ w_rk;
    for (int c = 0; c < 4; c++) begin
      w_imc[32*c +: 32] = imc_col(w_ark[32*c +: 32]);
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    unique case (r_fsm)
      IDLE:    if (start) w_fsm_nxt = ROUNDS;
      ROUNDS:  if (r_rnd == 5'd1) w_fsm_nxt = FINAL;
      FINAL:   w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clks) begin
    if (reset) r_fsm <= IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  always_ff @(posedge clks) begin
    if (reset) begin
      r_state   <= '0;
      r_rnd     <= '0;
      plainText <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (r_fsm)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state <= cipherText ^ w_rk;
            r_rnd   <= 5'(Nr - 1);
            busy    <= 1'b1;
          end
        end
        ROUNDS: begin
          r_state <= w_imc;
          r_rnd   <= r_rnd - 5'd1;
        end
        FINAL: begin
          plainText <= w_ark;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_cipher.sv
// Bench for inv_cipher: FIPS-197 vectors, handshake corners and a
// random round trip against a behavioural AES encryptor.
module tb_inv_cipher;

  logic clks = 1'b0;
  always #5 clks = ~clks;

  logic reset = 1'b1;
  logic st4 = 1'b0, st6 = 1'b0, st8 = 1'b0;
  logic [0:127] ct4 = '0, ct6 = '0, ct8 = '0;
  logic [0:128*11-1] keys4 = '0;
  logic [0:128*13-1] keys6 = '0;
  logic [0:128*15-1] keys8 = '0;
  logic [0:127] pt4, pt6, pt8;
  logic busy4, busy6, busy8, done4, done6, done8;

  int n_run = 0;
  int n_fail = 0;
  logic [7:0] sb [0:255];
  logic [127:0] g_s0;

  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY128 =
    {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  inv_cipher #(.Nk(4)) u4 (
    .clks(clks), .reset(reset), .start(st4), .cipherText(ct4),
    .keys(keys4), .plainText(pt4), .busy(busy4), .done(done4));
  inv_cipher #(.Nk(6)) u6 (
    .clks(clks), .reset(reset), .start(st6), .cipherText(ct6),
    .keys(keys6), .plainText(pt6), .busy(busy6), .done(done6));
  inv_cipher #(.Nk(8)) u8 (
    .clks(clks), .reset(reset), .start(st8), .cipherText(ct8),
    .keys(keys8), .plainText(pt8), .busy(busy8), .done(done8));

  always @(negedge clks) begin
    if (!reset) begin
      n_run++;
      if ((done4 && busy4) || (done6 && busy6) || (done8 && busy8)) begin
        n_fail++;
        $display("FAIL done_and_busy d=%b%b%b b=%b%b%b required not both",
                 done4, done6, done8, busy4, busy6, busy8);
      end
    end
  end

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = t[7] ? ({t[6:0], 1'b0} ^ 8'h1b) : {t[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [0:128*15-1] expand(input logic [255:0] key,
                                               input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0] rc;
    logic [0:128*15-1] res;
    res = '0;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 4*(nk+7); i++) res[32*i +: 32] = w[i];
    return res;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt,
                                           input logic [0:128*15-1] kb,
                                           input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] rk;
    logic [127:0] o;
    rk = kb[0 +: 128];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r+4*c] = sb[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) begin
        if (rd < nr) begin
          s[4*c]   = gm(t[4*c], 2) ^ gm(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 2) ^ gm(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 2) ^ gm(t[4*c+3], 3);
          s[4*c+3] = gm(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 2);
        end else begin
          for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
        end
      end
      rk = kb[128*rd +: 128];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input int nk, input logic st, input logic [127:0] ct,
                       input logic [0:128*15-1] kb);
    case (nk)
      4: begin st4 = st; ct4 = ct; keys4 = kb[0:128*11-1]; end
      6: begin st6 = st; ct6 = ct; keys6 = kb[0:128*13-1]; end
      default: begin st8 = st; ct8 = ct; keys8 = kb; end
    endcase
  endtask

  task automatic get(input int nk, output logic [127:0] pt,
                     output logic b, output logic d);
    case (nk)
      4: begin pt = pt4; b = busy4; d = done4; end
      6: begin pt = pt6; b = busy6; d = done6; end
      default: begin pt = pt8; b = busy8; d = done8; end
    endcase
  endtask

  // One block; a stray start with junk data is raised mid-flight.
  task automatic run_block(input int nk, input logic [127:0] ct,
                           input logic [0:128*15-1] kb,
                           output logic [127:0] pt, output int lat,
                           output int bcnt);
    logic b, d;
    drive(nk, 1'b1, ct, kb);
    @(posedge clks); #1;
    if (nk == 4) g_s0 = u4.r_state;
    drive(nk, 1'b0, rnd128(), kb);
    get(nk, pt, b, d);
    bcnt = b ? 1 : 0;
    lat = 0;
    d = 1'b0;
    while (!d && lat < 40) begin
      drive(nk, lat == 3, rnd128(), kb);
      @(posedge clks); #1;
      lat++;
      get(nk, pt, b, d);
      if (b) bcnt++;
    end
    drive(nk, 1'b0, rnd128(), kb);
  endtask

  task automatic test_reset();
    logic [0:128*15-1] kb;
    kb = expand(KEY128, 4);
    drive(4, 1'b1, CT128, kb);
    drive(6, 1'b0, '0, '0);
    drive(8, 1'b0, '0, '0);
    reset = 1'b1;
    repeat (2) @(posedge clks);
    #1;
    n_run += 4;
    if (pt4 !== 128'h0) begin
      n_fail++; $display("FAIL rst_pt got %h required 0", pt4);
    end
    if (busy4 !== 1'b0 || busy6 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy got %b%b%b required 000", busy4, busy6, busy8);
    end
    if (done4 !== 1'b0 || done6 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL rst_done got %b%b%b required 000", done4, done6, done8);
    end
    reset = 1'b0;
    drive(4, 1'b0, CT128, kb);
    @(posedge clks); #1;
    if (busy4 !== 1'b0) begin
      n_fail++; $display("FAIL rst_start_ignored busy=%b required 0", busy4);
    end
  endtask

  task automatic test_fips();
    logic [255:0] key;
    logic [127:0] ct, pt;
    logic [0:128*15-1] kb;
    logic [127:0] k10;
    int nk, lat, bcnt;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin nk = 4; key = KEY128; ct = CT128; end
        1: begin
          nk = 6;
          key = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
          ct = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        end
        default: begin
          nk = 8;
          key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
          ct = 128'h8ea2b7ca516745bfeafc49904b496089;
        end
      endcase
      kb = expand(key, nk);
      if (k == 0) begin
        k10 = kb[128*10 +: 128];
        n_run++;
        if (k10 !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
          n_fail++; $display("FAIL model_k10 got %h", k10);
        end
      end
      run_block(nk, ct, kb, pt, lat, bcnt);
      n_run += 3;
      if (lat !== nk + 6) begin
        n_fail++; $display("FAIL fips_lat nk=%0d got %0d required %0d", nk, lat, nk + 6);
      end
      if (bcnt !== nk + 6) begin
        n_fail++; $display("FAIL fips_busy nk=%0d got %0d required %0d", nk, bcnt, nk + 6);
      end
      if (pt !== PT_FIPS) begin
        n_fail++; $display("FAIL fips_pt nk=%0d got %h required %h", nk, pt, PT_FIPS);
      end
      if (k == 0) begin
        n_run++;
        if (g_s0 !== 128'h7ad5fda789ef4e272bca100b3d9ff59f) begin
          n_fail++; $display("FAIL fips_state_e0 got %h", g_s0);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:128*15-1] kb;
    logic [127:0] ptb, ctb, pt;
    logic [127:0] got [2];
    int td [2];
    int cyc, nd;
    logic b, d;
    kb = expand(KEY128, 4);
    ptb = rnd128();
    ctb = encrypt(ptb, kb, 10);
    got[0] = '0; got[1] = '0; td[0] = -1; td[1] = -1;
    drive(4, 1'b1, CT128, kb);
    @(posedge clks); #1;
    drive(4, 1'b1, rnd128(), kb);
    cyc = 0;
    nd = 0;
    while (nd < 2 && cyc < 60) begin
      @(posedge clks); #1;
      cyc++;
      get(4, pt, b, d);
      if (d) begin
        got[nd] = pt; td[nd] = cyc; nd++;
      end
      if (nd == 2) drive(4, 1'b0, rnd128(), kb);
      else if (d) drive(4, 1'b1, ctb, kb);
      else drive(4, 1'b1, rnd128(), kb);
    end
    n_run += 4;
    if (td[0] !== 10) begin
      n_fail++; $display("FAIL b2b_first_done got %0d required 10", td[0]);
    end
    if (td[1] - td[0] !== 11) begin
      n_fail++; $display("FAIL b2b_gap got %0d required 11", td[1] - td[0]);
    end
    if (got[0] !== PT_FIPS) begin
      n_fail++; $display("FAIL b2b_pt0 got %h required %h", got[0], PT_FIPS);
    end
    if (got[1] !== ptb) begin
      n_fail++; $display("FAIL b2b_pt1 got %h required %h", got[1], ptb);
    end
    repeat (3) @(posedge clks);
    #1;
    n_run++;
    if (pt4 !== ptb || done4 !== 1'b0 || busy4 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_hold pt=%h d=%b b=%b required %h 0 0", pt4, done4, busy4, ptb);
    end
  endtask

  task automatic test_reset_mid();
    logic [0:128*15-1] kb;
    logic [127:0] pt;
    int lat, bcnt;
    kb = expand(KEY128, 4);
    drive(4, 1'b1, CT128, kb);
    @(posedge clks); #1;
    drive(4, 1'b0, CT128, kb);
    repeat (5) @(posedge clks);
    #1;
    reset = 1'b1;
    @(posedge clks); #1;
    n_run++;
    if (pt4 !== 128'h0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset pt=%h b=%b d=%b required 0 0 0", pt4, busy4, done4);
    end
    reset = 1'b0;
    run_block(4, CT128, kb, pt, lat, bcnt);
    n_run += 2;
    if (lat !== 10) begin
      n_fail++; $display("FAIL mid_reset_lat got %0d required 10", lat);
    end
    if (pt !== PT_FIPS) begin
      n_fail++; $display("FAIL mid_reset_pt got %h required %h", pt, PT_FIPS);
    end
  endtask

  task automatic test_round_trip();
    logic [255:0] key;
    logic [127:0] ptx, ct, pt;
    logic [0:128*15-1] kb;
    int nk, lat, bcnt;
    for (int n = 0; n < 200; n++) begin
      nk = 4 + 2 * int'($urandom_range(0, 2));
      key = {rnd128(), rnd128()};
      ptx = rnd128();
      kb = expand(key, nk);
      ct = encrypt(ptx, kb, nk + 6);
      run_block(nk, ct, kb, pt, lat, bcnt);
      n_run += 3;
      if (pt !== ptx) begin
        n_fail++; $display("FAIL rt_pt n=%0d nk=%0d got %h required %h", n, nk, pt, ptx);
      end
      if (lat !== nk + 6) begin
        n_fail++; $display("FAIL rt_lat n=%0d got %0d required %0d", n, lat, nk + 6);
      end
      if (bcnt !== nk + 6) begin
        n_fail++; $display("FAIL rt_busy n=%0d got %0d required %0d", n, bcnt, nk + 6);
      end
    end
  endtask

  initial begin
    init_sbox();
    test_reset();
    test_fips();
    test_back_to_back();
    test_reset_mid();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
